// File: rtl/apb_master_pkg.sv
// Shared bus widths and one-hot state encoding for the APB master and the
// slave it talks to.
package apb_master_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;

   // One-hot state bit positions; the enum values below are built from them.
   localparam int ST_W       = 5;
   localparam int IDLE_BIT   = 0;
   localparam int SETUP_BIT  = 1;
   localparam int ACCESS_BIT = 2;
   localparam int RDWAIT_BIT = 3;
   localparam int RESP_BIT   = 4;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = ST_W'(1 << IDLE_BIT),
      ST_SETUP  = ST_W'(1 << SETUP_BIT),
      ST_ACCESS = ST_W'(1 << ACCESS_BIT),
      ST_RDWAIT = ST_W'(1 << RDWAIT_BIT),
      ST_RESP   = ST_W'(1 << RESP_BIT)
   } state_t;

   // Terminal value of the 2-bit SETUP counter for a given SETUP length (1..4).
   function automatic logic [1:0] setup_last(input int setup_cyc);
      return 2'(setup_cyc - 1);
   endfunction

endpackage

// File: rtl/apb_master.sv
// APB master: turns one local command at a time into a SETUP/ACCESS transfer
// on a PREADY-less APB bus and returns a single-cycle completion pulse.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int SETUP_CYC = 2
) (
   input  logic              PCLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA
);

   localparam logic [1:0] SETUP_LAST = setup_last(SETUP_CYC);

   state_t            r_state;
   logic [1:0]        r_cnt;
   logic [ADDR_W-1:0] r_paddr;
   logic              r_pwrite;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_psel;
   logic              r_penable;
   logic              r_rsp_valid;
   logic              r_rsp_write;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              w_idle;

   assign w_idle = r_state[IDLE_BIT];

   // Gated by RST so the requester sees not-ready during reset and ready the
   // moment reset releases, letting the very first edge accept a command.
   assign cmd_ready = w_idle & ~RST;

   assign PADDR     = r_paddr;
   assign PWRITE    = r_pwrite;
   assign PWDATA    = r_pwdata;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;

   // NOTE: all state is updated with non-blocking assignments so every branch
   // reads the pre-edge values regardless of statement order.
   always_ff @(posedge PCLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_paddr  <= cmd_addr;
                  r_pwrite <= cmd_write;
                  r_pwdata <= cmd_wdata;
                  r_psel   <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_cnt     <= '0;
                  r_penable <= 1'b1;
                  r_state   <= ST_ACCESS;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            ST_ACCESS: begin
               // PSEL drops here so the bus sees at least the RESP cycle idle.
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               if (r_pwrite) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_state     <= ST_RESP;
               end else begin
                  r_state <= ST_RDWAIT;
               end
            end
            ST_RDWAIT: begin
               // The slave registered its read data on the ACCESS edge.
               r_rsp_valid <= 1'b1;
               r_rsp_write <= 1'b0;
               r_rsp_rdata <= PRDATA;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_cnt     <= '0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
